// File: rtl/snake_engine.sv
// Snake game-state engine: circular body buffer, sequential self-collision scan
// between steps, optional edge wrap, win/restart handling and a body read port.
module snake_engine #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int XW       = 6,
  parameter int YW       = 6,
  parameter int MAX_LEN  = 64,
  parameter int LW       = 6,
  parameter int INIT_LEN = 4,
  parameter int INIT_X   = 10,
  parameter int INIT_Y   = 15,
  parameter int WRAP     = 0
) (
  input  logic          clk_25M,
  input  logic          rst_n,
  input  logic          step_i,
  input  logic          restart_i,
  input  logic [2:0]    key_stroke_i,
  input  logic [XW-1:0] cand_x_i,
  input  logic [YW-1:0] cand_y_i,
  input  logic [LW-1:0] rd_idx_i,
  output logic [XW-1:0] rd_x_o,
  output logic [YW-1:0] rd_y_o,
  output logic [XW-1:0] head_x_o,
  output logic [YW-1:0] head_y_o,
  output logic [XW-1:0] tail_x_o,
  output logic [YW-1:0] tail_y_o,
  output logic [XW-1:0] apple_x_o,
  output logic [YW-1:0] apple_y_o,
  output logic [LW:0]   length_o,
  output logic [10:0]   score_o,
  output logic [1:0]    game_state_o,
  output logic          busy_o
);

  localparam int CW  = XW + YW;
  localparam int LW1 = LW + 1;

  localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;
  localparam logic [1:0] GS_RUN = 2'd0, GS_PAUSE = 2'd1, GS_OVER = 2'd2, GS_WIN = 2'd3;

  localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_HEAD0   = XW'(INIT_X);
  localparam logic [XW-1:0] X_TAIL0   = XW'(INIT_X - INIT_LEN + 1);
  localparam logic [YW-1:0] Y_HEAD0   = YW'(INIT_Y);
  localparam logic [LW-1:0] PTR_HEAD0 = LW'(INIT_LEN - 1);
  localparam logic [LW:0]   LEN0      = LW1'(INIT_LEN);
  localparam logic [LW:0]   LEN_MAX   = LW1'(MAX_LEN);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SCAN, S_COMMIT, S_HALT} state_t;

  state_t        state_q;
  logic [LW-1:0] wr_ptr_q, head_ptr_q, tail_ptr_q, scan_ptr_q;
  logic [LW:0]   scan_cnt_q, length_q;
  logic [XW-1:0] head_x_q, tail_x_q, apple_x_q, nxt_x_q, rd_x_q;
  logic [YW-1:0] head_y_q, tail_y_q, apple_y_q, nxt_y_q, rd_y_q;
  logic [10:0]   score_q;
  logic [1:0]    gs_q, dir_q, pend_dir_q, move_dir_q;
  logic          pause_req_q, eat_q, busy_q;

  logic [CW-1:0] body_mem [MAX_LEN];
  logic          mem_we;
  logic [LW-1:0] mem_waddr;
  logic [CW-1:0] mem_wdata;

  logic [LW-1:0] head_ptr_inc, tail_ptr_inc;
  logic [CW-1:0] scan_cell, tail_cell;
  logic [XW-1:0] nxt_x_d;
  logic [YW-1:0] nxt_y_d;
  logic          edge_hit, key_ok, key_pause, scan_hit, scan_last;
  logic [1:0]    rev_dir;

  assign head_ptr_inc = head_ptr_q + LW'(1);
  assign tail_ptr_inc = tail_ptr_q + LW'(1);
  assign scan_cell    = body_mem[scan_ptr_q];
  assign tail_cell    = body_mem[tail_ptr_inc];

  assign rev_dir   = {dir_q[1], ~dir_q[0]};
  assign key_ok    = !key_stroke_i[2] && (key_stroke_i[1:0] != rev_dir);
  assign key_pause = (key_stroke_i == 3'd4);

  // The tail cell vacates on a non-eating move, so the first scanned entry is exempt.
  assign scan_hit  = ({nxt_x_q, nxt_y_q} == scan_cell) && !((scan_cnt_q == '0) && !eat_q);
  assign scan_last = (scan_cnt_q == length_q - LW1'(1));

  always_comb begin
    nxt_x_d  = head_x_q;
    nxt_y_d  = head_y_q;
    edge_hit = 1'b0;
    case (pend_dir_q)
      D_UP:
        if (head_y_q == '0) begin
          if (WRAP != 0) nxt_y_d = Y_MAX;
          else           edge_hit = 1'b1;
        end else nxt_y_d = head_y_q - YW'(1);
      D_DOWN:
        if (head_y_q == Y_MAX) begin
          if (WRAP != 0) nxt_y_d = '0;
          else           edge_hit = 1'b1;
        end else nxt_y_d = head_y_q + YW'(1);
      D_LEFT:
        if (head_x_q == '0) begin
          if (WRAP != 0) nxt_x_d = X_MAX;
          else           edge_hit = 1'b1;
        end else nxt_x_d = head_x_q - XW'(1);
      default:
        if (head_x_q == X_MAX) begin
          if (WRAP != 0) nxt_x_d = '0;
          else           edge_hit = 1'b1;
        end else nxt_x_d = head_x_q + XW'(1);
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = {X_TAIL0 + XW'(wr_ptr_q), Y_HEAD0};
    if (!restart_i) begin
      if (state_q == S_INIT) begin
        mem_we = 1'b1;
      end else if (state_q == S_COMMIT) begin
        mem_we    = 1'b1;
        mem_waddr = head_ptr_inc;
        mem_wdata = {nxt_x_q, nxt_y_q};
      end
    end
  end

  always_ff @(posedge clk_25M) begin
    if (mem_we) body_mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;  wr_ptr_q <= '0;  head_ptr_q <= PTR_HEAD0;  tail_ptr_q <= '0;
      scan_ptr_q <= '0;  scan_cnt_q <= '0;  length_q <= LEN0;  score_q <= '0;
      head_x_q <= X_HEAD0;  head_y_q <= Y_HEAD0;  tail_x_q <= X_TAIL0;  tail_y_q <= Y_HEAD0;
      apple_x_q <= '0;  apple_y_q <= '0;  nxt_x_q <= '0;  nxt_y_q <= '0;
      gs_q <= GS_PAUSE;  dir_q <= D_RIGHT;  pend_dir_q <= D_RIGHT;  move_dir_q <= D_RIGHT;
      pause_req_q <= 1'b0;  eat_q <= 1'b0;  busy_q <= 1'b1;
    end else if (restart_i) begin
      state_q <= S_INIT;  wr_ptr_q <= '0;  head_ptr_q <= PTR_HEAD0;  tail_ptr_q <= '0;
      scan_ptr_q <= '0;  scan_cnt_q <= '0;  length_q <= LEN0;  score_q <= '0;
      head_x_q <= X_HEAD0;  head_y_q <= Y_HEAD0;  tail_x_q <= X_TAIL0;  tail_y_q <= Y_HEAD0;
      apple_x_q <= '0;  apple_y_q <= '0;  nxt_x_q <= '0;  nxt_y_q <= '0;
      gs_q <= GS_PAUSE;  dir_q <= D_RIGHT;  pend_dir_q <= D_RIGHT;  move_dir_q <= D_RIGHT;
      pause_req_q <= 1'b0;  eat_q <= 1'b0;  busy_q <= 1'b1;
    end else begin
      if (gs_q == GS_RUN || gs_q == GS_PAUSE) begin
        if (key_ok) begin
          pend_dir_q <= key_stroke_i[1:0];
          if (gs_q == GS_PAUSE) gs_q <= GS_RUN;
        end else if (key_pause && gs_q == GS_RUN) begin
          pause_req_q <= 1'b1;
        end
      end

      case (state_q)
        S_INIT: begin
          wr_ptr_q <= wr_ptr_q + LW'(1);
          if (wr_ptr_q == PTR_HEAD0) begin
            apple_x_q <= cand_x_i;
            apple_y_q <= cand_y_i;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (step_i && gs_q == GS_RUN) begin
            if (pause_req_q) begin
              gs_q        <= GS_PAUSE;
              pause_req_q <= 1'b0;
            end else if (edge_hit) begin
              gs_q    <= GS_OVER;
              state_q <= S_HALT;
            end else begin
              nxt_x_q    <= nxt_x_d;
              nxt_y_q    <= nxt_y_d;
              eat_q      <= ({nxt_x_d, nxt_y_d} == {apple_x_q, apple_y_q});
              move_dir_q <= pend_dir_q;
              scan_ptr_q <= tail_ptr_q;
              scan_cnt_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          scan_ptr_q <= scan_ptr_q + LW'(1);
          scan_cnt_q <= scan_cnt_q + LW1'(1);
          if (scan_hit) begin
            gs_q    <= GS_OVER;
            busy_q  <= 1'b0;
            state_q <= S_HALT;
          end else if (scan_last) begin
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          head_ptr_q <= head_ptr_inc;
          head_x_q   <= nxt_x_q;
          head_y_q   <= nxt_y_q;
          dir_q      <= move_dir_q;
          busy_q     <= 1'b0;
          if (eat_q) begin
            if (score_q != '1) score_q <= score_q + 11'd1;
            length_q  <= length_q + LW1'(1);
            apple_x_q <= cand_x_i;
            apple_y_q <= cand_y_i;
          end else begin
            tail_ptr_q           <= tail_ptr_inc;
            {tail_x_q, tail_y_q} <= tail_cell;
          end
          if (eat_q && (length_q + LW1'(1) == LEN_MAX)) begin
            gs_q    <= GS_WIN;
            state_q <= S_HALT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      rd_x_q <= '0;
      rd_y_q <= '0;
    end else if (restart_i) begin
      rd_x_q <= '0;
      rd_y_q <= '0;
    end else begin
      {rd_x_q, rd_y_q} <= body_mem[head_ptr_q - rd_idx_i];
    end
  end

  assign rd_x_o       = rd_x_q;
  assign rd_y_o       = rd_y_q;
  assign head_x_o     = head_x_q;
  assign head_y_o     = head_y_q;
  assign tail_x_o     = tail_x_q;
  assign tail_y_o     = tail_y_q;
  assign apple_x_o    = apple_x_q;
  assign apple_y_o    = apple_y_q;
  assign length_o     = length_q;
  assign score_o      = score_q;
  assign game_state_o = gs_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: one edge-terminating and one wrapping instance
// share stimulus; expected values are hand-computed positions and counters.
module tb_snake_engine;
  logic       clk_25M = 1'b0;
  logic       rst_n = 1'b0;
  logic       step = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] key = 3'd7;
  logic [5:0] cand_x = 6'd0, cand_y = 6'd0;
  logic [5:0] rd_idx = 6'd0;

  logic [5:0]  rd_x0, rd_y0, head_x0, head_y0, tail_x0, tail_y0, apple_x0, apple_y0;
  logic [6:0]  length0;
  logic [10:0] score0;
  logic [1:0]  gs0;
  logic        busy0;
  logic [5:0]  rd_x1, rd_y1, head_x1, head_y1, tail_x1, tail_y1, apple_x1, apple_y1;
  logic [6:0]  length1;
  logic [10:0] score1;
  logic [1:0]  gs1;
  logic        busy1;

  int n_vec = 0;
  int n_err = 0;

  always #20 clk_25M = ~clk_25M;

  snake_engine #(.WRAP(0)) dut0 (
    .clk_25M(clk_25M), .rst_n(rst_n), .step_i(step), .restart_i(restart),
    .key_stroke_i(key), .cand_x_i(cand_x), .cand_y_i(cand_y), .rd_idx_i(rd_idx),
    .rd_x_o(rd_x0), .rd_y_o(rd_y0), .head_x_o(head_x0), .head_y_o(head_y0),
    .tail_x_o(tail_x0), .tail_y_o(tail_y0), .apple_x_o(apple_x0), .apple_y_o(apple_y0),
    .length_o(length0), .score_o(score0), .game_state_o(gs0), .busy_o(busy0));

  snake_engine #(.WRAP(1)) dut1 (
    .clk_25M(clk_25M), .rst_n(rst_n), .step_i(step), .restart_i(restart),
    .key_stroke_i(key), .cand_x_i(cand_x), .cand_y_i(cand_y), .rd_idx_i(rd_idx),
    .rd_x_o(rd_x1), .rd_y_o(rd_y1), .head_x_o(head_x1), .head_y_o(head_y1),
    .tail_x_o(tail_x1), .tail_y_o(tail_y1), .apple_x_o(apple_x1), .apple_y_o(apple_y1),
    .length_o(length1), .score_o(score1), .game_state_o(gs1), .busy_o(busy1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_head(input string tag, input int x, input int y);
    chk({tag, "_hx"}, head_x0, x);
    chk({tag, "_hy"}, head_y0, y);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 400) begin
      @(negedge clk_25M);
      n++;
    end
    if (busy0 || busy1) chk("idle_timeout", 1, 0);
  endtask

  task automatic press(input logic [2:0] k);
    @(negedge clk_25M);
    key = k;
    @(negedge clk_25M);
    key = 3'd7;
  endtask

  task automatic do_step();
    @(negedge clk_25M);
    step = 1'b1;
    @(negedge clk_25M);
    step = 1'b0;
    wait_idle();
  endtask

  task automatic do_restart();
    @(negedge clk_25M);
    restart = 1'b1;
    @(negedge clk_25M);
    restart = 1'b0;
    wait_idle();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    do begin
      @(negedge clk_25M);
      n++;
    end while (busy0 && n < 50);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cand_x = 6'd30;
    cand_y = 6'd3;
    repeat (3) @(negedge clk_25M);
    chk_head("rst", 10, 15);
    chk("rst_tx", tail_x0, 7);
    chk("rst_len", length0, 4);
    chk("rst_score", score0, 0);
    chk("rst_apple", apple_x0, 0);
    chk("rst_gs", gs0, 1);
    chk("rst_busy", busy0, 1);
    chk("rst_rdx", rd_x0, 0);

    rst_n = 1'b1;
    count_busy(n);
    chk("init_busy_cycles", n, 4);
    chk("init_apple_x", apple_x0, 30);
    chk("init_apple_y", apple_y0, 3);
    chk("init_gs", gs0, 1);

    // First move right, with exact latency of length+2 cycles
    press(3'd3);
    chk("resume_gs", gs0, 0);
    @(negedge clk_25M);
    step = 1'b1;
    @(negedge clk_25M);
    step = 1'b0;
    repeat (4) @(negedge clk_25M);
    chk("lat_before", head_x0, 10);
    @(negedge clk_25M);
    chk("lat_after", head_x0, 11);
    chk_head("step1", 11, 15);
    chk("step1_tx", tail_x0, 8);
    chk("step1_ty", tail_y0, 15);
    chk("step1_score", score0, 0);
    chk("step1_gs", gs0, 0);

    rd_idx = 6'd1;
    @(negedge clk_25M);
    chk("rd1_x", rd_x0, 10);
    rd_idx = 6'd3;
    @(negedge clk_25M);
    chk("rd3_x", rd_x0, 8);
    chk("rd3_y", rd_y0, 15);
    rd_idx = 6'd0;

    press(3'd2);
    do_step();
    chk_head("reverse_ignored", 12, 15);

    // Pause, stepping frozen, resume, then restart mid-scan
    press(3'd4);
    chk("pause_pending_gs", gs0, 0);
    do_step();
    chk("paused_gs", gs0, 1);
    do_step();
    do_step();
    do_step();
    chk_head("paused", 12, 15);
    chk("paused_score", score0, 0);
    press(3'd3);
    chk("unpause_gs", gs0, 0);

    cand_x = 6'd11;
    cand_y = 6'd15;
    @(negedge clk_25M);
    step = 1'b1;
    @(negedge clk_25M);
    step = 1'b0;
    chk("scan_busy", busy0, 1);
    restart = 1'b1;
    @(negedge clk_25M);
    restart = 1'b0;
    chk_head("restart", 10, 15);
    chk("restart_len", length0, 4);
    chk("restart_gs", gs0, 1);
    chk("restart_busy", busy0, 1);
    chk("restart_apple", apple_x0, 0);
    count_busy(n);
    chk("restart_busy_cycles", n, 4);
    chk("restart_apple_x", apple_x0, 11);

    // Eat the apple at (11,15)
    cand_x = 6'd20;
    cand_y = 6'd20;
    press(3'd3);
    do_step();
    chk_head("eat", 11, 15);
    chk("eat_score", score0, 1);
    chk("eat_len", length0, 5);
    chk("eat_tx", tail_x0, 7);
    chk("eat_ax", apple_x0, 20);
    chk("eat_ay", apple_y0, 20);

    // UP, LEFT, DOWN into own body
    press(3'd0);
    do_step();
    chk_head("up", 11, 14);
    press(3'd2);
    do_step();
    chk_head("left", 10, 14);
    chk("left_tx", tail_x0, 9);
    press(3'd1);
    do_step();
    chk("collide_gs", gs0, 2);
    chk_head("collide", 10, 14);
    press(3'd3);
    do_step();
    do_step();
    chk("halt_gs", gs0, 2);
    chk_head("halt", 10, 14);
    chk("halt_score", score0, 1);
    chk("halt_len", length0, 5);

    // Moving onto the vacating tail is legal
    cand_x = 6'd30;
    cand_y = 6'd3;
    do_restart();
    press(3'd0);
    do_step();
    press(3'd2);
    do_step();
    press(3'd1);
    do_step();
    chk("tailmove_gs", gs0, 0);
    chk_head("tailmove", 9, 15);
    chk("tailmove_tx", tail_x0, 10);
    chk("tailmove_ty", tail_y0, 15);

    // Right edge: terminate (dut0) versus wrap (dut1)
    do_restart();
    press(3'd3);
    for (int i = 0; i < 29; i++) do_step();
    chk("edge_pre_x0", head_x0, 39);
    chk("edge_pre_x1", head_x1, 39);
    do_step();
    chk("edge_gs0", gs0, 2);
    chk_head("edge", 39, 15);
    chk("wrap_x1", head_x1, 0);
    chk("wrap_y1", head_y1, 15);
    chk("wrap_gs1", gs1, 0);
    do_step();
    chk("edge_frozen_x0", head_x0, 39);
    chk("edge_frozen_gs0", gs0, 2);
    chk("wrap_next_x1", head_x1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
